mc_control_fsm: RTL and testbench

Main control sequencer for the multicycle MIPS CPU. It decodes the latched instruction's opcode/funct and steps the shared datapath (PC, unified instruction/data memory, IR, register file, ALU) through fetch, decode, execute, memory and writeback states. It emits every datapath select and write strobe. It stretches memory states until the unified memory reports ready, which removes the slow-clock requirement on memory.

---
 rtl/mc_ctrl_pkg.sv | 76 +++++++
 rtl/mc_control_fsm_if.sv | 50 +++++
 rtl/mc_alu_decoder.sv | 34 +++
 rtl/mc_control_fsm.sv | 259 +++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control sequencer:
//   - state_e      : sequencer states (ADDIWB exists only when ADDI_EN is defined)
//   - OP_* / FN_*  : opcode and R-type funct encodings
//   - ALU_*        : alu_ctl codes
//   - ALUB_*       : alu_src_b operand selects
//   - PCSRC_*      : pc_source selects
//   - is_mem_state : states that stretch until the unified memory is ready
// Optional feature macro: ADDI_EN (adds the addi instruction path).
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    localparam int OP_W = 6;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
`ifdef ADDI_EN
        ,
        S_ADDIWB = 4'd10
`endif
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operand B selects
    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    // Next-PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for the states that wait on mem_ready
    function automatic logic is_mem_state(input state_e s);
        logic r;
        case (s)
            S_FETCH, S_MEMRD, S_MEMWR: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_control_fsm_if
// Control bundle between the sequencer and the multicycle datapath.
//   Datapath -> sequencer : opcode, funct, zero, mem_ready
//   Sequencer -> datapath : PC/memory/IR/regfile strobes and selects,
//                           ALU controls, illegal_op and mem_timeout pulses
// Modports:
//   master : the control sequencer (drives selects and strobes)
//   slave  : the datapath/memory side (drives status back)
// -----------------------------------------------------------------------------
interface mc_control_fsm_if;
    import mc_ctrl_pkg::*;

    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] funct;
    logic            zero;
    logic            mem_ready;

    logic            pc_write;
    logic            pc_write_cond;
    logic            pc_en;
    logic            ior_d;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            mem_to_reg;
    logic            reg_dst;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [2:0]      alu_ctl;
    logic [1:0]      pc_source;
    logic            illegal_op;
    logic            mem_timeout;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, pc_en, ior_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_ctl, pc_source, illegal_op, mem_timeout
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_en, ior_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_ctl, pc_source, illegal_op, mem_timeout
    );

endinterface

// File: rtl/mc_alu_decoder.sv
// -----------------------------------------------------------------------------
// mc_alu_decoder
// Combinational R-type funct decoder.
// Ports:
//   funct_i       in  6  IR[5:0]
//   alu_ctl_o     out 3  ALU operation for the funct (add when unsupported)
//   funct_legal_o out 1  funct is one of add/sub/and/or/slt
// -----------------------------------------------------------------------------
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctl_o,
    output logic       funct_legal_o
);

    // funct to ALU operation lookup
    always_comb begin
        alu_ctl_o     = ALU_ADD;
        funct_legal_o = 1'b0;
        case (funct_i)
            FN_ADD: begin alu_ctl_o = ALU_ADD; funct_legal_o = 1'b1; end
            FN_SUB: begin alu_ctl_o = ALU_SUB; funct_legal_o = 1'b1; end
            FN_AND: begin alu_ctl_o = ALU_AND; funct_legal_o = 1'b1; end
            FN_OR:  begin alu_ctl_o = ALU_OR;  funct_legal_o = 1'b1; end
            FN_SLT: begin alu_ctl_o = ALU_SLT; funct_legal_o = 1'b1; end
            default: begin
                alu_ctl_o     = ALU_ADD;
                funct_legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Main control sequencer of the multicycle MIPS CPU. Steps the shared datapath
// through FETCH/DECODE/execute/memory/writeback and stretches FETCH, MEMRD and
// MEMWR until the unified memory reports mem_ready.
// Parameters:
//   MEM_WAIT_MAX  wait cycles in a memory state before mem_timeout pulses
//                 (0 disables the pulse; the state still waits for mem_ready)
// Ports:
//   clk   in  rising-edge system clock
//   rst   in  asynchronous active-low reset
//   bus   mc_control_fsm_if.master (opcode/funct/zero/mem_ready in,
//         all datapath selects, strobes and status pulses out)
// Optional feature macro: ADDI_EN (opcode 0x08 via MEMADR -> ADDIWB).
// -----------------------------------------------------------------------------
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
)
(
    input  logic              clk,
    input  logic              rst,
    mc_control_fsm_if.master  bus
);

    localparam logic [3:0] WAIT_MAX_C = 4'(MEM_WAIT_MAX);

    state_e     state_q;
    state_e     state_d;
    // Low from reset until the first clock edge after release; holds every
    // strobe and the FETCH advance off so nothing fires in that window.
    logic       run_q;
    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;
    logic       mem_timeout_q;
    logic       mem_timeout_d;

    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       ior_d_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       mem_to_reg_s;
    logic       reg_dst_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [2:0] alu_ctl_s;
    logic [1:0] pc_source_s;
    logic       illegal_s;

    logic [2:0] dec_alu_ctl_s;
    logic       dec_legal_s;

    mc_alu_decoder u_alu_dec (
        .funct_i       (bus.funct),
        .alu_ctl_o     (dec_alu_ctl_s),
        .funct_legal_o (dec_legal_s)
    );

    // State, run flag, wait counter and timeout pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_FETCH;
            run_q         <= 1'b0;
            wait_cnt_q    <= 4'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_q         <= 1'b1;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Wait counter: counts not-ready cycles in a memory state, zero elsewhere.
    // Leaving a memory state always passes through a non-waiting cycle, so the
    // count starts from zero on every entry.
    always_comb begin
        wait_cnt_d    = 4'd0;
        mem_timeout_d = 1'b0;
        if (run_q && is_mem_state(state_q) && !bus.mem_ready) begin
            if (wait_cnt_q != 4'd15) begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
            // Fires only on the step onto the limit, so saturation cannot repeat it
            if ((WAIT_MAX_C != 4'd0) && (wait_cnt_q != WAIT_MAX_C) &&
                (wait_cnt_d == WAIT_MAX_C)) begin
                mem_timeout_d = 1'b1;
            end else begin
                mem_timeout_d = 1'b0;
            end
        end else begin
            wait_cnt_d    = 4'd0;
            mem_timeout_d = 1'b0;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d         = S_FETCH;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        ior_d_s         = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = ALUB_REG;
        alu_ctl_s       = 3'b000;
        pc_source_s     = PCSRC_ALU;
        illegal_s       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = ALUB_FOUR;
                alu_ctl_s   = ALU_ADD;
                pc_source_s = PCSRC_ALU;
                if (run_q && bus.mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    ir_write_s = 1'b0;
                    pc_write_s = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target computed here so BRANCH can take it from ALUOut
                alu_src_b_s = ALUB_IMM_SH;
                alu_ctl_s   = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = S_MEMADR;
`endif
                    default: begin
                        illegal_s = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = ALUB_IMM;
                alu_ctl_s   = ALU_ADD;
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWR;
`ifdef ADDI_EN
                end else if (bus.opcode == OP_ADDI) begin
                    state_d = S_ADDIWB;
`endif
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                ior_d_s    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                reg_dst_s    = 1'b0;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                // Request held for the whole stretch; memory commits on mem_ready
                mem_write_s = 1'b1;
                ior_d_s     = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = ALUB_REG;
                alu_ctl_s   = dec_alu_ctl_s;
                if (dec_legal_s) begin
                    state_d = S_ALUWB;
                end else begin
                    illegal_s = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b1;
                mem_to_reg_s = 1'b0;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_src_b_s     = ALUB_REG;
                alu_ctl_s       = ALU_SUB;
                pc_write_cond_s = 1'b1;
                pc_source_s     = PCSRC_ALUOUT;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = PCSRC_JUMP;
                state_d     = S_FETCH;
            end
`ifdef ADDI_EN
            S_ADDIWB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b0;
                mem_to_reg_s = 1'b0;
                state_d      = S_FETCH;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes are qualified by run_q, which the asynchronous reset clears at
    // once, so no request or write survives a reset.
    assign bus.pc_write      = pc_write_s & run_q;
    assign bus.pc_write_cond = pc_write_cond_s & run_q;
    assign bus.pc_en         = (pc_write_s | (pc_write_cond_s & bus.zero)) & run_q;
    assign bus.mem_read      = mem_read_s & run_q;
    assign bus.mem_write     = mem_write_s & run_q;
    assign bus.ir_write      = ir_write_s & run_q;
    assign bus.reg_write     = reg_write_s & run_q;
    assign bus.illegal_op    = illegal_s & run_q;
    assign bus.ior_d         = ior_d_s;
    assign bus.mem_to_reg    = mem_to_reg_s;
    assign bus.reg_dst       = reg_dst_s;
    assign bus.alu_src_a     = alu_src_a_s;
    assign bus.alu_src_b     = alu_src_b_s;
    assign bus.alu_ctl       = alu_ctl_s;
    assign bus.pc_source     = pc_source_s;
    assign bus.mem_timeout   = mem_timeout_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Scoreboard bench for mc_control_fsm. Each cycle's stimulus (mem_ready,
// opcode, funct, zero) is queued together with the full expected control
// vector; the queue is replayed one entry per cycle and every popped entry is
// compared against the DUT outputs half a cycle after the rising edge.
// Vector bit order: {pc_write, pc_write_cond, pc_en, ior_d, mem_read,
// mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
// alu_src_b[1:0], alu_ctl[2:0], pc_source[1:0], illegal_op, mem_timeout}.
// Build with ADDI_EN defined to exercise the addi path.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mc_control_fsm_if bus ();

    mc_control_fsm #(.MEM_WAIT_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int check_cnt = 0;
    int err_cnt   = 0;

    typedef struct {
        logic        rdy;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [19:0] exp;
    } step_t;

    step_t sb_q[$];
    string tag_q[$];

    logic [19:0] obs_s;
    assign obs_s = {bus.pc_write, bus.pc_write_cond, bus.pc_en, bus.ior_d,
                    bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                    bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                    bus.alu_ctl, bus.pc_source, bus.illegal_op, bus.mem_timeout};

    // Expected control vectors, written straight from the state output table
    localparam logic [19:0] V_RST      = {11'b00000000000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] V_FETCH_W  = {11'b00001000000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] V_FETCH_GO = {11'b10101010000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] V_DECODE   = {11'b00000000000, 2'b11, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] V_DEC_ILL  = {11'b00000000000, 2'b11, 3'b010, 2'b00, 1'b1, 1'b0};
    localparam logic [19:0] V_MEMADR   = {11'b00000000001, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] V_MEMRD    = {11'b00011000000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] V_MEMWB    = {11'b00000001010, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] V_MEMWR    = {11'b00010100000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] V_MEMWR_TO = {11'b00010100000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] V_ALUWB    = {11'b00000000110, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] V_BR_T     = {11'b01100000001, 2'b00, 3'b110, 2'b01, 1'b0, 1'b0};
    localparam logic [19:0] V_BR_NT    = {11'b01000000001, 2'b00, 3'b110, 2'b01, 1'b0, 1'b0};
    localparam logic [19:0] V_JUMP     = {11'b10100000000, 2'b00, 3'b000, 2'b10, 1'b0, 1'b0};
    localparam logic [19:0] V_ADDIWB   = {11'b00000000010, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};

    function automatic logic [19:0] exec_vec(input logic [2:0] ac);
        return {11'b00000000001, 2'b00, ac, 2'b00, 1'b0, 1'b0};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Single comparison point: counts every check, reports mismatches
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", tag, obs, exp);
        end
    endtask

    task automatic push_step(input string tag, input logic rdy, input logic [5:0] op,
                             input logic [5:0] fn, input logic z, input logic [19:0] e);
        step_t s;
        s.rdy = rdy;
        s.op  = op;
        s.fn  = fn;
        s.z   = z;
        s.exp = e;
        sb_q.push_back(s);
        tag_q.push_back(tag);
    endtask

    // Replay the queue: drive at the falling edge, compare 1 time unit later
    task automatic run_queue();
        step_t s;
        string t;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            t = tag_q.pop_front();
            @(negedge clk);
            bus.mem_ready = s.rdy;
            bus.opcode    = s.op;
            bus.funct     = s.fn;
            bus.zero      = s.z;
            #1;
            check_eq(t, 32'(obs_s), 32'(s.exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] fns [5];
        logic [2:0] acs [5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        acs = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

        rst           = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.zero      = 1'b0;

        // Reset state and release: nothing requested before the first edge
        repeat (3) @(negedge clk);
        #1 check_eq("reset_vec", 32'(obs_s), 32'(V_RST));
        @(negedge clk);
        rst = 1'b1;
        #1 check_eq("release_pre_edge", 32'(obs_s), 32'(V_RST));

        // sw stalled in MEMWR, then reset arrives mid-hold
        push_step("sw_fetch_wait", 1'b0, 6'h2B, 6'h00, 1'b0, V_FETCH_W);
        push_step("sw_fetch",      1'b1, 6'h2B, 6'h00, 1'b0, V_FETCH_GO);
        push_step("sw_decode",  rnd_bit(), 6'h2B, 6'h00, 1'b0, V_DECODE);
        push_step("sw_memadr",  rnd_bit(), 6'h2B, 6'h00, 1'b0, V_MEMADR);
        for (int i = 0; i < 3; i++) push_step("sw_memwr_hold", 1'b0, 6'h2B, 6'h00, 1'b0, V_MEMWR);
        run_queue();
        @(negedge clk);
        #1 check_eq("memwr_before_rst", 32'(obs_s), 32'(V_MEMWR));
        #1 rst = 1'b0;
        #1 check_eq("rst_async_memwr", 32'(obs_s), 32'(V_RST));
        @(negedge clk);
        rst = 1'b1;

        // lw: 2 FETCH waits, 1 MEMRD wait -> 8 cycles
        push_step("lw_fetch_w1", 1'b0, 6'h23, 6'h00, 1'b0, V_FETCH_W);
        push_step("lw_fetch_w2", 1'b0, 6'h23, 6'h00, 1'b0, V_FETCH_W);
        push_step("lw_fetch",    1'b1, 6'h23, 6'h00, 1'b0, V_FETCH_GO);
        push_step("lw_decode",   rnd_bit(), 6'h23, 6'h00, 1'b0, V_DECODE);
        push_step("lw_memadr",   rnd_bit(), 6'h23, 6'h00, 1'b0, V_MEMADR);
        push_step("lw_memrd_w",  1'b0, 6'h23, 6'h00, 1'b0, V_MEMRD);
        push_step("lw_memrd",    1'b1, 6'h23, 6'h00, 1'b0, V_MEMRD);
        push_step("lw_memwb",    rnd_bit(), 6'h23, 6'h00, 1'b0, V_MEMWB);

        // R-type: all five functs, 4 cycles each
        for (int k = 0; k < 5; k++) begin
            push_step("r_fetch",  1'b1, 6'h00, fns[k], 1'b0, V_FETCH_GO);
            push_step("r_decode", rnd_bit(), 6'h00, fns[k], 1'b0, V_DECODE);
            push_step("r_exec",   rnd_bit(), 6'h00, fns[k], 1'b0, exec_vec(acs[k]));
            push_step("r_aluwb",  rnd_bit(), 6'h00, fns[k], 1'b0, V_ALUWB);
        end

        // beq taken and not taken
        push_step("beq_t_fetch",  1'b1, 6'h04, 6'h00, 1'b1, V_FETCH_GO);
        push_step("beq_t_decode", rnd_bit(), 6'h04, 6'h00, 1'b1, V_DECODE);
        push_step("beq_t_branch", rnd_bit(), 6'h04, 6'h00, 1'b1, V_BR_T);
        push_step("beq_n_fetch",  1'b1, 6'h04, 6'h00, 1'b0, V_FETCH_GO);
        push_step("beq_n_decode", rnd_bit(), 6'h04, 6'h00, 1'b0, V_DECODE);
        push_step("beq_n_branch", rnd_bit(), 6'h04, 6'h00, 1'b0, V_BR_NT);

        // j, then an illegal opcode that returns straight to FETCH
        push_step("j_fetch",   1'b1, 6'h02, 6'h00, 1'b0, V_FETCH_GO);
        push_step("j_decode",  rnd_bit(), 6'h02, 6'h00, 1'b0, V_DECODE);
        push_step("j_jump",    rnd_bit(), 6'h02, 6'h00, 1'b0, V_JUMP);
        push_step("ill_fetch", 1'b1, 6'h3F, 6'h00, 1'b0, V_FETCH_GO);
        push_step("ill_decode", rnd_bit(), 6'h3F, 6'h00, 1'b0, V_DEC_ILL);

        // sw with 20 wait cycles: count reaches 15 after 15 waits, pulse shows
        // in the 16th MEMWR cycle and only there
        push_step("swto_fetch",  1'b1, 6'h2B, 6'h00, 1'b0, V_FETCH_GO);
        push_step("swto_decode", rnd_bit(), 6'h2B, 6'h00, 1'b0, V_DECODE);
        push_step("swto_memadr", rnd_bit(), 6'h2B, 6'h00, 1'b0, V_MEMADR);
        for (int i = 1; i <= 20; i++) begin
            push_step("swto_memwr_wait", 1'b0, 6'h2B, 6'h00, 1'b0,
                      (i == 16) ? V_MEMWR_TO : V_MEMWR);
        end
        push_step("swto_memwr_done", 1'b1, 6'h2B, 6'h00, 1'b0, V_MEMWR);

        // addi: legal only when the feature is built in
        push_step("addi_fetch", 1'b1, 6'h08, 6'h00, 1'b0, V_FETCH_GO);
`ifdef ADDI_EN
        push_step("addi_decode", rnd_bit(), 6'h08, 6'h00, 1'b0, V_DECODE);
        push_step("addi_memadr", rnd_bit(), 6'h08, 6'h00, 1'b0, V_MEMADR);
        push_step("addi_wb",     rnd_bit(), 6'h08, 6'h00, 1'b0, V_ADDIWB);
`else
        push_step("addi_decode_ill", rnd_bit(), 6'h08, 6'h00, 1'b0, V_DEC_ILL);
`endif
        push_step("final_fetch", 1'b0, 6'h00, 6'h00, 1'b0, V_FETCH_W);
        run_queue();

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
